// File: rtl/serial_cmp_pkg.sv
// Shared types for the bit-serial magnitude comparator: FSM states, the {gt,lt} result pair,
// and the bit-counter width helper.
package serial_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic gt;
        logic lt;
    } cmp_res_t;

    // A one-bit operand still needs a one-bit counter, so never return zero.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/cmp_bit_cell.sv
// Single-bit magnitude comparator stage, MSB-first: once gt or lt is set it sticks.
// Purely combinational (0 cycles); no flow control.
module cmp_bit_cell (
    input  logic a_bit,
    input  logic b_bit,
    input  logic gt_in,
    input  logic lt_in,
    output logic gt_out,
    output logic lt_out
);

    assign gt_out = gt_in | (~lt_in & a_bit & ~b_bit);
    assign lt_out = lt_in | (~gt_in & ~a_bit & b_bit);

endmodule

// File: rtl/serial_mag_comparator.sv
// Bit-serial unsigned comparator: walks a/b MSB-first through cmp_bit_cell, one bit per clock.
// Latency WIDTH+1 clocks incl. start cycle (less with EARLY_EXIT); start is ignored while busy.
module serial_mag_comparator
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    cmp_res_t         run_q, run_d;
    cmp_res_t         res_q, res_d;
    logic             eq_q, eq_d;

    logic             cell_gt;
    logic             cell_lt;
    logic             shift_exit;

    cmp_bit_cell u_cell (
        .a_bit  (sa_q[WIDTH-1]),
        .b_bit  (sb_q[WIDTH-1]),
        .gt_in  (run_q.gt),
        .lt_in  (run_q.lt),
        .gt_out (cell_gt),
        .lt_out (cell_lt)
    );

    assign shift_exit = (cnt_q == '0) || (EARLY_EXIT && (cell_gt || cell_lt));

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        res_d   = res_q;
        eq_d    = eq_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    cnt_d   = CNT_LOAD;
                    run_d   = '0;
                    res_d   = '0;
                    eq_d    = 1'b0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                run_d.gt = cell_gt;
                run_d.lt = cell_lt;
                sa_d     = sa_q << 1;
                sb_d     = sb_q << 1;
                cnt_d    = cnt_q - CNT_W'(1);
                if (shift_exit) begin
                    res_d.gt = cell_gt;
                    res_d.lt = cell_lt;
                    eq_d     = ~(cell_gt | cell_lt);
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            cnt_q   <= '0;
            run_q   <= '0;
            res_q   <= '0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            res_q   <= res_d;
            eq_q    <= eq_d;
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign gt   = res_q.gt;
    assign lt   = res_q.lt;
    assign eq   = eq_q;

endmodule

// File: doc/serial_mag_comparator.md
# serial_mag_comparator

Bit-serial unsigned magnitude comparator. It accepts two WIDTH-bit operands on a start strobe and walks them MSB-first through a 1-bit comparator cell, one bit per clock. It then reports greater/equal/less with a done pulse. It sits directly upstream of the single-bit comparator stage: it sequences the operand bits and the running comparison state into that cell and registers the cell's result each cycle.

## Interface
- WIDTH, default 8: operand width in bits; legal range ≥1.
- EARLY_EXIT, default 0: when set to 1, the comparison terminates on the first differing bit instead of always taking WIDTH cycles.
- clk, input, 1: single clock; all logic is on the rising edge.
- rst_n, input, 1: reset, synchronous and active-low.
- start, input, 1: request a comparison; sampled only in IDLE or DONE.
- a, input, WIDTH: operand A, unsigned; captured on an accepted start.
- b, input, WIDTH: operand B, unsigned; captured on an accepted start.
- busy, output, 1: high while in SHIFT.
- done, output, 1: one-cycle pulse when the result becomes valid.
- gt, output, 1: A > B; held until the next accepted start.
- eq, output, 1: A == B; held until the next accepted start.
- lt, output, 1: A < B; held until the next accepted start.

## Operation
- FSM states: IDLE, SHIFT, DONE. Encodings are defined in the package.
- IDLE or DONE with start=1 (accepted start):
  - load sa<=a and sb<=b;
  - clear the running flags gt_r and lt_r;
  - load bit counter cnt<=WIDTH-1;
  - clear the gt/eq/lt outputs;
  - go to SHIFT.
- IDLE or DONE with start=0: DONE→IDLE, IDLE stays in IDLE.
- SHIFT, each cycle:
  - the cell receives sa[WIDTH-1], sb[WIDTH-1], gt_r and lt_r;
  - register its outputs: gt_r<=gt_r | (~lt_r & a_bit & ~b_bit) and lt_r<=lt_r | (~gt_r & ~a_bit & b_bit);
  - shift sa and sb left by one;
  - decrement cnt.
- SHIFT exit: leave when cnt==0. With EARLY_EXIT=1, also leave when the cell output has gt or lt set. On exit go to DONE and latch gt<=gt_next, lt<=lt_next, eq<=~(gt_next|lt_next).
- Result latching: the result is latched in the same edge that enters DONE.
- done: asserted exactly while in DONE.
- start during SHIFT: ignored. No queuing, and the operands are not re-sampled.
- Invariant: at most one of gt_r/lt_r is ever set, and exactly one of gt/eq/lt is high whenever a result is held.
- Reset (rst_n=0 at an edge, including mid-SHIFT): state returns to IDLE. busy, done, gt, eq and lt all go to 0. sa, sb, cnt, gt_r and lt_r are cleared. Any operation in progress is abandoned with no done pulse.
- Reset value of every output: 0. An all-zero gt/eq/lt means no result yet.

## Timing
- Accepted start at edge 0 (state becomes SHIFT after edge 0).
- Fixed mode (EARLY_EXIT=0):
  - bits WIDTH-1..0 are processed at edges 1..WIDTH;
  - DONE and the result are visible after edge WIDTH;
  - done is high for exactly one cycle;
  - start-to-done latency is WIDTH+1 clocks including the start cycle. For WIDTH=8, done is high in the 9th cycle after the start cycle.
- EARLY_EXIT=1: if the first differing bit is bit k, DONE follows edge WIDTH-k. Equal operands still take the full WIDTH cycles.
- Back-to-back operation: start may be held high through DONE. A new comparison then begins with no IDLE gap, and throughput is one result per WIDTH+1 cycles.
- busy is high from the edge after acceptance through the last SHIFT cycle. It is low in DONE.
- WIDTH=1: exactly one SHIFT cycle; cnt is 0 on entry.

## Structure
- Package serial_cmp_pkg holds:
  - the state typedef (IDLE/SHIFT/DONE);
  - a 2-bit result typedef {gt, lt};
  - the localparam for counter width, $clog2(WIDTH) with a minimum of 1.
- One sub-module, cmp_bit_cell: a combinational single-bit stage.
  - inputs: a_bit, b_bit, gt_in, lt_in;
  - outputs: gt_out, lt_out;
  - it is instantiated once.
- The top level holds the FSM, shift registers, counter and output registers. Target size is about 150 lines of RTL.

## Test plan
- WIDTH=8, a=0xA5, b=0xA5, start pulsed once → done in the 9th cycle after start with eq=1, gt=0, lt=0. busy is high for exactly 8 cycles.
- a=0x80, b=0x7F → gt=1. With EARLY_EXIT=0, done comes 9 cycles after start. With EARLY_EXIT=1, done comes 2 cycles after start.
- a=0x3C, b=0x3D → lt=1. With EARLY_EXIT=1, done comes after the full 9 cycles because the differing bit is bit 0.
- Start held high continuously with operands changing every cycle → results complete back-to-back every 9 cycles. Each result matches the operands present at its accepted start; starts during SHIFT are ignored.
- rst_n driven low for one edge at SHIFT cycle 4 → the next cycle shows all outputs 0 and state IDLE, with no done pulse. A subsequent start with a=0x01, b=0x00 gives gt=1.
- WIDTH=1: (a,b) = (0,0), (0,1), (1,0), (1,1) → eq, lt, gt, eq respectively, each with done 2 cycles after start.
